ps2_keyboard: RTL and testbench

PS/2 keyboard receiver and scan-code decoder that produces the `keycode` byte consumed by `render` and the kid movement logic. Samples the keyboard's open-collector clock/data lines in the `clk` domain, deframes 11-bit PS/2 frames, strips `E0`/`F0` prefixes and holds the make code of the currently pressed key. Sits at top level between the PS/2 pins and `render`.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_filter.sv | 35 +++
 rtl/ps2_keyboard.sv | 151 +++++++++++++++
 tb/tb_ps2_keyboard.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and frame FSM state type for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a glitch filter; the output only moves after
// FILTER_LEN consecutive samples disagree with it. Idles high like the bus.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      filt <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: conditions the bus lines, deframes 11-bit frames and
// decodes E0/F0-prefixed scan codes into the make code of the held key.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic [7:0] scan_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic clk_f, data_f, clk_d, fall;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk (clk),
    .rst (rst),
    .raw (ps2_clk),
    .filt(clk_f)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk (clk),
    .rst (rst),
    .raw (ps2_data),
    .filt(data_f)
  );

  assign fall = clk_d & ~clk_f;

  frame_state_t    state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            par_bit, par_n;
  logic [7:0]      scan_n;
  logic            bv_n, err_n;
  logic [TW-1:0]   tcnt;
  logic            ext_pend, brk_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      scan_byte  <= KEY_NONE;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      clk_d      <= 1'b1;
      tcnt       <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bit    <= par_n;
      scan_byte  <= scan_n;
      byte_valid <= bv_n;
      frame_err  <= err_n;
      clk_d      <= clk_f;
      // Saturates so a long idle bus never wraps back into a false "fresh" count.
      if (fall)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT))
        tcnt <= tcnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_bit;
    scan_n    = scan_byte;
    bv_n      = 1'b0;
    err_n     = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!data_f) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shreg_n   = {data_f, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7)
            state_n = PARITY;
        end
        PARITY: begin
          par_n   = data_f;
          state_n = STOP;
        end
        STOP: begin
          if (data_f && parity_ok(shreg, par_bit)) begin
            scan_n = shreg;
            bv_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TW'(TIMEOUT)) begin
      err_n   = 1'b1;
      shreg_n = '0;
      state_n = IDLE;
    end
  end

  // Break only clears the held key if it names that exact key, so releasing an
  // older key while a newer one is down leaves the newer one held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keycode  <= KEY_NONE;
      extended <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_valid) begin
      if (scan_byte == PS2_EXT) begin
        ext_pend <= 1'b1;
      end else if (scan_byte == PS2_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        if (!brk_pend) begin
          keycode  <= scan_byte;
          extended <= ext_pend;
        end else if (keycode == scan_byte && extended == ext_pend) begin
          keycode  <= KEY_NONE;
          extended <= 1'b0;
        end
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: table of frames with expected decoder state,
// plus hand sequences for timeout, glitch and mid-frame reset.
module tb_ps2_keyboard;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode, scan_byte;
  logic       extended, byte_valid, frame_err;

  int tests = 0;
  int fails = 0;
  int bv_cnt = 0;
  int err_cnt = 0;
  logic prev_pulse = 1'b0;

  ps2_keyboard #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .extended  (extended),
    .scan_byte (scan_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Every pulse must be one cycle wide and byte_valid/frame_err exclusive.
  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (frame_err)  err_cnt++;
    if (byte_valid || frame_err) begin
      tests++;
      if ((byte_valid && frame_err) || prev_pulse) begin
        fails++;
        $display("FAIL pulse_shape: bv=%0b err=%0b prev=%0b required single exclusive pulse",
                 byte_valid, frame_err, prev_pulse);
      end
    end
    prev_pulse = byte_valid || frame_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par, input bit stop);
    return {stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    send_bits(mk(d, bad_par, stop), 11);
    wait_clk(3 * HALF);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         stop;
    int         bv;
    int         err;
    logic [7:0] scan;
    logic [7:0] key;
    logic       ext;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  initial begin
    int b0, e0;

    vecs[0]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 8'h1C, 1'b0}; // make 1C
    vecs[1]  = '{8'hF0, 0, 1, 1, 0, 8'hF0, 8'h1C, 1'b0};
    vecs[2]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 8'h00, 1'b0}; // break 1C
    vecs[3]  = '{8'hE0, 0, 1, 1, 0, 8'hE0, 8'h00, 1'b0};
    vecs[4]  = '{8'h6B, 0, 1, 1, 0, 8'h6B, 8'h6B, 1'b1}; // extended make
    vecs[5]  = '{8'hE0, 0, 1, 1, 0, 8'hE0, 8'h6B, 1'b1};
    vecs[6]  = '{8'hF0, 0, 1, 1, 0, 8'hF0, 8'h6B, 1'b1};
    vecs[7]  = '{8'h6B, 0, 1, 1, 0, 8'h6B, 8'h00, 1'b0}; // extended break
    vecs[8]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 8'h1C, 1'b0};
    vecs[9]  = '{8'h23, 0, 1, 1, 0, 8'h23, 8'h23, 1'b0};
    vecs[10] = '{8'hF0, 0, 1, 1, 0, 8'hF0, 8'h23, 1'b0};
    vecs[11] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 8'h23, 1'b0}; // old key release
    vecs[12] = '{8'hF0, 0, 1, 1, 0, 8'hF0, 8'h23, 1'b0};
    vecs[13] = '{8'h23, 0, 1, 1, 0, 8'h23, 8'h00, 1'b0};
    vecs[14] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 8'h1C, 1'b0};
    vecs[15] = '{8'h1C, 1, 1, 0, 1, 8'h1C, 8'h1C, 1'b0}; // bad parity
    vecs[16] = '{8'h5A, 0, 0, 0, 1, 8'h1C, 8'h1C, 1'b0}; // bad stop
    vecs[17] = '{8'hF0, 0, 1, 1, 0, 8'hF0, 8'h1C, 1'b0};
    vecs[18] = '{8'h33, 1, 1, 0, 1, 8'hF0, 8'h1C, 1'b0}; // error drops brk_pend
    vecs[19] = '{8'h23, 0, 1, 1, 0, 8'h23, 8'h23, 1'b0};
    vecs[20] = '{8'hE0, 0, 1, 1, 0, 8'hE0, 8'h23, 1'b0};
    vecs[21] = '{8'h44, 0, 0, 0, 1, 8'hE0, 8'h23, 1'b0}; // error drops ext_pend
    vecs[22] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 8'h1C, 1'b0};

    wait_clk(4);
    @(negedge clk);
    check("rst_keycode", keycode, 8'h00);
    check("rst_extended", extended, 1'b0);
    check("rst_scan", scan_byte, 8'h00);
    check("rst_bv", byte_valid, 1'b0);
    check("rst_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_clk(30);

    for (int i = 0; i < NV; i++) begin
      b0 = bv_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop);
      check($sformatf("v%0d_bv", i), bv_cnt - b0, vecs[i].bv);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].err);
      check($sformatf("v%0d_scan", i), scan_byte, vecs[i].scan);
      check($sformatf("v%0d_key", i), keycode, vecs[i].key);
      check($sformatf("v%0d_ext", i), extended, vecs[i].ext);
    end

    // Timeout: start + 4 data bits then silence.
    b0 = bv_cnt;
    e0 = err_cnt;
    send_bits(mk(8'h5A, 0, 1), 5);
    wait_clk(TO + 10);
    wait_clk(30);
    @(negedge clk);
    check("to_err", err_cnt - e0, 1);
    check("to_bv", bv_cnt - b0, 0);
    check("to_key", keycode, 8'h1C);
    send_frame(8'h23, 0, 1);
    check("to_next_key", keycode, 8'h23);
    check("to_next_bv", bv_cnt - b0, 1);

    // Short clock glitch while data is low must not look like a start bit.
    b0 = bv_cnt;
    e0 = err_cnt;
    ps2_data = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(3);
    ps2_clk = 1'b1;
    wait_clk(HALF);
    ps2_data = 1'b1;
    wait_clk(HALF);
    send_frame(8'h5A, 0, 1);
    check("gl_bv", bv_cnt - b0, 1);
    check("gl_err", err_cnt - e0, 0);
    check("gl_scan", scan_byte, 8'h5A);
    check("gl_key", keycode, 8'h5A);

    // Reset mid-frame.
    send_bits(mk(8'h29, 0, 1), 5);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(2);
    @(negedge clk);
    check("mr_keycode", keycode, 8'h00);
    check("mr_extended", extended, 1'b0);
    check("mr_scan", scan_byte, 8'h00);
    check("mr_bv", byte_valid, 1'b0);
    check("mr_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_clk(30);
    b0 = bv_cnt;
    e0 = err_cnt;
    send_frame(8'hE0, 0, 1);
    send_frame(8'h75, 0, 1);
    check("mr_next_bv", bv_cnt - b0, 2);
    check("mr_next_err", err_cnt - e0, 0);
    check("mr_next_key", keycode, 8'h75);
    check("mr_next_ext", extended, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
